// File: rtl/io_port_responder_if.sv
// Data-memory bus seen by the I/O responder: the core drives address/strobes,
// the responder returns combinational load data and its window hit.
interface io_port_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        io_hit;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  io_hit
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output io_hit
    );
endinterface

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: PortOut register, synchronized PortIn, and a
// change-event FIFO that software drains by reading the EVENT register.
module io_port_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0040,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    io_port_responder_if.slave         bus,
    input  logic [7:0]                 PortIn,
    output logic [31:0]                PortOut
);

    localparam int unsigned PtrW = (CNT_W > 1) ? CNT_W - 1 : 1;

    localparam logic [2:0] RegPortOut = 3'd0;
    localparam logic [2:0] RegPortIn  = 3'd1;
    localparam logic [2:0] RegStatus  = 3'd2;
    localparam logic [2:0] RegEvent   = 3'd3;
    localparam logic [2:0] RegCtrl    = 3'd4;

    logic [31:0]      port_out_q, port_out_d;
    logic             capture_en_q, capture_en_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [7:0]       sync1_q, sync2_q, last_q;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic [2:0]       offset;
    logic             hit;
    logic             wr_en;
    logic             rd_en;
    logic             empty;
    logic             full;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic [31:0]      status_word;
    logic [7:0]       head;
    logic             unused_addr_lsb;

    // Word-aligned decode; byte lanes within a word are not distinguished.
    assign offset          = bus.Address[4:2];
    assign unused_addr_lsb = ^bus.Address[1:0];
    assign hit             = (bus.Address[31:5] == BASE_ADDR[31:5]);
    assign wr_en           = bus.MemWrite & hit;
    assign rd_en           = bus.MemRead & hit;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign head     = mem_q[rptr_q];
    assign pop      = rd_en & (offset == RegEvent) & ~empty;
    assign push_req = (sync2_q != last_q) & capture_en_q;
    // A same-edge pop frees a slot, so a full FIFO still accepts the push.
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        port_out_d   = port_out_q;
        capture_en_d = capture_en_q;
        overflow_d   = overflow_q;
        if (wr_en) begin
            if (offset == RegPortOut) begin
                port_out_d = bus.WriteData;
            end else if (offset == RegCtrl) begin
                capture_en_d = bus.WriteData[0];
                if (bus.WriteData[1]) begin
                    overflow_d = 1'b0;
                end
            end
        end
        // Setting overflow wins over a same-edge software clear.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q   <= '0;
            capture_en_q <= 1'b0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            last_q       <= '0;
        end else begin
            port_out_q   <= port_out_d;
            capture_en_q <= capture_en_d;
            overflow_q   <= overflow_d;
            count_q      <= count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            sync1_q      <= PortIn;
            sync2_q      <= sync1_q;
            last_q       <= sync2_q;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= sync2_q;
        end
    end

    always_comb begin
        status_word               = '0;
        status_word[0]            = ~empty;
        status_word[1]            = full;
        status_word[2]            = overflow_q;
        status_word[4 +: CNT_W]   = count_q;
    end

    always_comb begin
        bus.ReadData = '0;
        if (rd_en) begin
            unique case (offset)
                RegPortOut: bus.ReadData = port_out_q;
                RegPortIn:  bus.ReadData = {24'h0, sync2_q};
                RegStatus:  bus.ReadData = status_word;
                RegEvent:   bus.ReadData = empty ? 32'h0 : {24'h0, head};
                RegCtrl:    bus.ReadData = {31'h0, capture_en_q};
                default:    bus.ReadData = '0;
            endcase
        end
    end

    assign bus.io_hit = hit;
    assign PortOut    = port_out_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder with a queue-based reference model
// and literal load expectations.
module tb_io_port_responder;

    localparam logic [31:0] BASE  = 32'h1001_0040;
    localparam int          DEPTH = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  pin   = 8'h00;
    logic [31:0] port_out;

    logic        lit_en  = 1'b0;
    logic [31:0] lit_val = '0;

    int n_vec = 0;
    int n_bad = 0;

    io_port_responder_if bus_if ();

    io_port_responder #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_if),
        .PortIn (pin),
        .PortOut(port_out)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_port_out = '0;
    logic        m_cap      = 1'b0;
    logic        m_ovf      = 1'b0;
    logic [7:0]  m_fifo [$];
    logic [7:0]  m_smp [3]  = '{8'h0, 8'h0, 8'h0};
    logic        m_hit;
    logic [2:0]  m_off;
    logic        m_push;
    logic        m_drop;

    function automatic logic exp_hit();
        return bus_if.Address[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] exp_rd();
        logic [31:0] r;
        int          sz;
        r  = '0;
        sz = m_fifo.size();
        if (exp_hit() && bus_if.MemRead) begin
            case (bus_if.Address[4:2])
                3'd0: r = m_port_out;
                3'd1: r = {24'h0, m_smp[1]};
                3'd2: r = 32'(sz * 16 + (m_ovf ? 4 : 0) + (sz == DEPTH ? 2 : 0) + (sz != 0 ? 1 : 0));
                3'd3: r = (sz != 0) ? {24'h0, m_fifo[0]} : 32'h0;
                3'd4: r = {31'h0, m_cap};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_port_out = '0;
                m_cap      = 1'b0;
                m_ovf      = 1'b0;
                m_fifo.delete();
                m_smp      = '{8'h0, 8'h0, 8'h0};
            end else begin
                m_hit  = exp_hit();
                m_off  = bus_if.Address[4:2];
                m_push = m_cap && (m_smp[1] != m_smp[2]);
                m_drop = 1'b0;
                if (bus_if.MemRead && m_hit && m_off == 3'd3 && m_fifo.size() > 0) begin
                    void'(m_fifo.pop_front());
                end
                if (m_push) begin
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(m_smp[1]);
                    else m_drop = 1'b1;
                end
                if (bus_if.MemWrite && m_hit) begin
                    if (m_off == 3'd0) begin
                        m_port_out = bus_if.WriteData;
                    end else if (m_off == 3'd4) begin
                        m_cap = bus_if.WriteData[0];
                        if (bus_if.WriteData[1]) m_ovf = 1'b0;
                    end
                end
                if (m_drop) m_ovf = 1'b1;
                m_smp[2] = m_smp[1];
                m_smp[1] = m_smp[0];
                m_smp[0] = pin;
            end
        end
    end

    // Single compare process: model checks every cycle, plus literal loads.
    initial begin
        logic [31:0] er;
        forever begin
            @(negedge clk);
            er = exp_rd();
            n_vec++;
            if (bus_if.io_hit !== exp_hit()) begin
                n_bad++;
                $display("FAIL io_hit @%0t: got %b want %b", $time, bus_if.io_hit, exp_hit());
            end
            n_vec++;
            if (bus_if.ReadData !== er) begin
                n_bad++;
                $display("FAIL ReadData @%0t addr %h: got %h want %h", $time, bus_if.Address,
                         bus_if.ReadData, er);
            end
            n_vec++;
            if (port_out !== m_port_out) begin
                n_bad++;
                $display("FAIL PortOut @%0t: got %h want %h", $time, port_out, m_port_out);
            end
            if (lit_en) begin
                n_vec++;
                if (bus_if.ReadData !== lit_val) begin
                    n_bad++;
                    $display("FAIL literal load @%0t addr %h: got %h want %h", $time,
                             bus_if.Address, bus_if.ReadData, lit_val);
                end
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic chk, input logic [31:0] v);
        @(posedge clk);
        #1;
        bus_if.Address   = a;
        bus_if.WriteData = wd;
        bus_if.MemWrite  = we;
        bus_if.MemRead   = re;
        lit_en           = chk;
        lit_val          = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        bus(BASE + 32'(off), d, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] v);
        bus(BASE + 32'(off), 32'h0, 1'b0, 1'b1, 1'b1, v);
    endtask

    initial begin
        bus_if.Address   = '0;
        bus_if.WriteData = '0;
        bus_if.MemWrite  = 1'b0;
        bus_if.MemRead   = 1'b0;

        // 1: write ignored under reset, then takes effect after release.
        wr(8'h00, 32'hDEAD_BEEF);
        rd(8'h00, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        wr(8'h00, 32'hDEAD_BEEF);
        rd(8'h00, 32'hDEAD_BEEF);

        // 2: single change event with capture enabled.
        wr(8'h10, 32'h1);
        pin = 8'h5A;
        idle(1);
        rd(8'h04, 32'h5A);
        rd(8'h08, 32'h11);
        rd(8'h0C, 32'h5A);
        rd(8'h08, 32'h00);

        // 3: overflow on the fifth event, drain, clear overflow.
        for (int i = 1; i <= 5; i++) begin
            pin = 8'(i * 8'h11);
            idle(4);
        end
        rd(8'h08, 32'h47);
        for (int i = 1; i <= 4; i++) rd(8'h0C, 32'(i * 8'h11));
        rd(8'h0C, 32'h0);
        rd(8'h08, 32'h04);
        wr(8'h10, 32'h3);
        rd(8'h08, 32'h00);

        // 4: full FIFO with same-edge push and pop, pointers wrapping.
        for (int i = 1; i <= 4; i++) begin
            pin = 8'(8'h60 + i);
            idle(4);
        end
        rd(8'h08, 32'h43);
        pin = 8'h65;
        idle(1);
        rd(8'h0C, 32'h61);
        rd(8'h08, 32'h43);
        for (int k = 0; k < 8; k++) begin
            pin = 8'(8'h66 + k);
            idle(1);
            rd(8'h0C, 32'(8'h62 + k));
        end
        rd(8'h08, 32'h43);
        for (int k = 0; k < 4; k++) rd(8'h0C, 32'(8'h6A + k));
        rd(8'h08, 32'h00);

        // 5: changes while capture is off leave no stale event.
        wr(8'h10, 32'h0);
        pin = 8'h01;
        idle(3);
        pin = 8'h02;
        idle(3);
        wr(8'h10, 32'h1);
        idle(3);
        rd(8'h08, 32'h00);
        rd(8'h04, 32'h02);
        rd(8'h10, 32'h01);

        // 6: misses, reserved offsets, RO writes, then reset mid-burst.
        bus(BASE + 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        bus(32'h1001_0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        bus(BASE + 32'h20, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0);
        rd(8'h14, 32'h0);
        wr(8'h18, 32'hFFFF_FFFF);
        wr(8'h04, 32'hFFFF_FFFF);
        rd(8'h1C, 32'h0);
        wr(8'h00, 32'h1234_5678);
        rd(8'h00, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            pin = 8'(8'h70 + i);
            idle(4);
        end
        bus(BASE + 32'h0C, 32'hFF, 1'b1, 1'b1, 1'b1, 32'h70);
        rd(8'h08, 32'h31);
        bus(BASE + 32'h2C, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        rd(8'h08, 32'h31);
        @(posedge clk);
        #1;
        reset            = 1'b0;
        bus_if.Address   = BASE + 32'h08;
        bus_if.MemWrite  = 1'b0;
        bus_if.MemRead   = 1'b1;
        lit_en           = 1'b1;
        lit_val          = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        rd(8'h08, 32'h00);
        rd(8'h00, 32'h0);
        rd(8'h0C, 32'h0);
        idle(1);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
Memory-mapped I/O responder on the processor's data-memory bus (Address/WriteData/MemWrite/MemRead/ReadData), the target side of load/store accesses.
- Drives the 32-bit PortOut register.
- Synchronizes the 8-bit PortIn.
- Logs every PortIn change into a small FIFO that software drains with lw.
- Sits beside DataMemory; the top level muxes ReadData using io_hit.

Parameters:
BASE_ADDR, 32'h1001_0040, byte base of the 32-byte register window (bits [4:0] must be 0)
FIFO_DEPTH, 4, change-event FIFO entries (power of 2, 2..16)
CNT_W, 3, width of the occupancy count, equal to log2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Address  input  32  byte address from the ALU result
WriteData  input  32  store data (ReadData2)
MemWrite  input  1  store strobe, sampled at the clk edge
MemRead  input  1  load strobe; a pop takes effect at the clk edge
PortIn  input  8  asynchronous external input
ReadData  output  32  combinational load data; 0 when not hit or MemRead=0
io_hit  output  1  combinational: Address[31:5]==BASE_ADDR[31:5]
PortOut  output  32  registered output port

Behaviour:
Register map (offset = Address[4:0]; Address[1:0] ignored):
- 0x00 PORT_OUT: RW, 32 bits.
- 0x04 PORT_IN: RO, {24'b0, sync2}.
- 0x08 STATUS: RO. bit0 = not_empty, bit1 = full, bit2 = overflow (sticky), bits[3+CNT_W:4] = count, other bits 0.
- 0x0C EVENT: RO. Reads {24'b0, FIFO head}, or 0 when empty. A read pops the head.
- 0x10 CTRL: RW, bit0 only = capture_en. Write bit1=1 clears overflow (self-clearing, reads 0).
- 0x14-0x1C: read 0, writes ignored.
- Writes to RO offsets are ignored.

Reset (reset=0, asynchronous):
- PortOut=0, capture_en=0, overflow=0, count=0, read/write pointers=0.
- sync1=sync2=last=0.
- ReadData and io_hit stay combinational during reset; no pop or write takes effect.

Writes:
- On the clk edge when MemWrite & io_hit, the register at the offset is updated from WriteData.
- MemWrite and MemRead asserted together: the write is performed, and a pop still occurs if the offset is EVENT.

Input path, updated every edge:
- sync1<=PortIn; sync2<=sync1; last<=sync2.
- change = (sync2 != last).
- push = change & capture_en. The pushed value is sync2.
- Latency: PortIn is stable before edge E1. PORT_IN shows the new value after E2. The push occurs at E3, and STATUS and EVENT reflect it after E3.
- last tracks sync2 even while capture is disabled, so no stale event appears when capture is enabled.

FIFO (circular, pointers wrap modulo FIFO_DEPTH):
- pop = MemRead & io_hit & offset==0x0C & count!=0. A pop on an empty FIFO has no effect.
- push only, not full: store the value, wptr+1, count+1.
- push only, full: drop the value, overflow<=1, FIFO unchanged.
- push and pop, full: both happen, count unchanged, no overflow.
- push and pop, count 1: the head is returned and popped, the new entry is stored, count stays 1.
- push on empty with a same-cycle EVENT read: the read returns 0 and does not pop; the entry becomes visible next cycle.
- Clearing overflow and setting overflow in the same edge: set wins.

ReadData:
- Purely combinational from the current state.
- The value returned by an EVENT read is the head before the pop.

Reset mid-operation:
- All state clears immediately and the FIFO contents are discarded.

Test Plan:
1. Reset low, then sw 0xDEADBEEF to BASE+0x00 -> PortOut=0 during reset; PortOut=0xDEADBEEF one edge after the write; lw BASE+0x00 returns 0xDEADBEEF.
2. Enable capture (CTRL=1), PortIn 0x00->0x5A -> PORT_IN=0x5A after 2 edges; STATUS=0x11 after 3 edges; lw EVENT returns 0x5A; STATUS=0x00 after the pop edge.
3. With capture on, apply 5 distinct PortIn values spaced 4 cycles apart, DEPTH=4 -> STATUS=0x47 (count 4, full, not_empty, overflow); EVENT reads return the first 4 values in order; a 5th read returns 0; CTRL write 0x3 clears overflow -> STATUS=0x00.
4. FIFO full, then simultaneous push (PortIn change) and EVENT pop -> oldest value returned, count stays 4, overflow stays 0; pointer wrap verified by 8 further push/pop pairs returning values in order.
5. Capture disabled, PortIn toggles 0x01/0x02, then CTRL=1 with no further change -> count stays 0; PORT_IN=0x02.
6. Address BASE+0x20 or DataMemory range with MemRead=1 -> io_hit=0, ReadData=0, no pop; assert reset mid-burst with count=3 -> count=0, PortOut=0 immediately (asynchronous).
